// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: framed LSB-first parallel-to-serial transmitter.
// Optional even-parity bit after the data: define SERIAL_TX_PARITY_EN.
module serial_pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [5:0]       bit_idx
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;
`endif

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [5:0]       idx_q;
    logic [5:0]       idx_d;
    logic             x_q;
    logic             x_d;
    logic             last_bit;
    logic             accept;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;
    logic par_d;
`endif

    // Status decode from the registered state; ready also covers the
    // final bit so a new frame can follow with no idle gap.
    always_comb begin
        last_bit = (state_q == DATA) && (idx_q == LAST);
`ifdef SERIAL_TX_PARITY_EN
        done = (state_q == PAR);
`else
        done = last_bit;
`endif
        busy    = (state_q != IDLE);
        ready   = (state_q == IDLE) || done;
        accept  = load && ready;
        bit_idx = (state_q == DATA) ? idx_q : 6'd0;
        x       = x_q;
    end

    // Next-state, shift and next-line-value logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        x_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                idx_d = 6'd0;
            end
            START: begin
                state_d = DATA;
                idx_d   = 6'd0;
            end
            DATA: begin
                if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                    idx_d = 6'd0;
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 6'd1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                idx_d   = 6'd0;
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = 6'd0;
            end
        endcase

        // A load is only taken in IDLE or the done cycle; it always
        // restarts at the start bit with a freshly captured word.
        if (accept) begin
            state_d = START;
            shift_d = data_in;
            idx_d   = 6'd0;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^data_in;
`endif
        end

        // The line is registered, so it is selected by the state we enter.
        unique case (state_d)
            START:   x_d = 1'b1;
            DATA:    x_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PAR:     x_d = par_q;
`endif
            default: x_d = 1'b0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= 6'd0;
            x_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: randomized and directed checks of serial_pattern_tx
// against a frame-queue reference model (WIDTH=8 and WIDTH=1 instances).
module tb_serial_pattern_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int L8 = 8 + 1 + PAR_EN;

    typedef struct packed {
        logic       x;
        logic       done;
        logic [5:0] idx;
    } cyc_t;
    typedef cyc_t cyc_q_t[$];

    logic       clk;
    logic       Reset;
    logic [7:0] data_in;
    logic       d1;
    logic       load;
    logic       ready8, x8, busy8, done8;
    logic [5:0] idx8;
    logic       ready1, x1, busy1, done1;
    logic [5:0] idx1;

    int checks;
    int errors;
    cyc_q_t q8;
    cyc_q_t q1;

    serial_pattern_tx #(.WIDTH(8)) dut (
        .Clk(clk), .Reset(Reset), .data_in(data_in), .load(load),
        .ready(ready8), .x(x8), .busy(busy8), .done(done8), .bit_idx(idx8)
    );

    serial_pattern_tx #(.WIDTH(1)) dut1 (
        .Clk(clk), .Reset(Reset), .data_in(d1), .load(load),
        .ready(ready1), .x(x1), .busy(busy1), .done(done1), .bit_idx(idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole frame as the line should show it, one entry per cycle.
    function automatic cyc_q_t frame(int w, logic [31:0] d);
        cyc_q_t f;
        cyc_t c;
        logic p;
        p = 1'b0;
        c.x = 1'b1; c.done = 1'b0; c.idx = 6'd0;
        f.push_back(c);
        for (int i = 0; i < w; i++) begin
            c.x = d[i];
            c.done = (i == w - 1) && (PAR_EN == 0);
            c.idx = 6'(i);
            p = p ^ d[i];
            f.push_back(c);
        end
        if (PAR_EN != 0) begin
            c.x = p; c.done = 1'b1; c.idx = 6'd0;
            f.push_back(c);
        end
        return f;
    endfunction

    // {x, busy, done, ready, bit_idx} expected for the current cycle.
    function automatic logic [9:0] exp_of(cyc_q_t q);
        if (q.size() == 0) return {4'b0001, 6'd0};
        return {q[0].x, 1'b1, q[0].done, q[0].done, q[0].idx};
    endfunction

    function automatic logic [9:0] obs8();
        return {x8, busy8, done8, ready8, idx8};
    endfunction

    function automatic logic [9:0] obs1();
        return {x1, busy1, done1, ready1, idx1};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge,
    // and return at the following falling edge for sampling.
    task automatic tick(input logic ld, input logic [7:0] d, input logic rst);
        logic r8, r1;
        cyc_q_t f;
        load = ld; data_in = d; d1 = d[0]; Reset = rst;
        @(posedge clk);
        r8 = (q8.size() == 0) || q8[0].done;
        r1 = (q1.size() == 0) || q1[0].done;
        if (q8.size() != 0) void'(q8.pop_front());
        if (q1.size() != 0) void'(q1.pop_front());
        if (rst) begin
            q8.delete();
            q1.delete();
        end else if (ld) begin
            if (r8) begin
                f = frame(8, {24'd0, d});
                foreach (f[i]) q8.push_back(f[i]);
            end
            if (r1) begin
                f = frame(1, {31'd0, d[0]});
                foreach (f[i]) q1.push_back(f[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (obs8() !== {4'b0001, 6'd0} || obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
        end
    endtask

    task automatic test_a5();
        logic [8:0] line;
        int ndone;
        line = 9'b101001011;
        ndone = 0;
        tick(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= L8 + 2; k++) begin
            checks++;
            if (obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL a5_model cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
            if (k <= 9) begin
                checks++;
                if (x8 !== line[k-1] || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL a5_line cyc %0d got x=%b busy=%b exp x=%b busy=1",
                             k, x8, busy8, line[k-1]);
                end
            end
            if (done8) ndone++;
            tick(1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL a5_done_count got %0d exp 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        tick(1'b1, 8'hFF, 1'b0);
        for (int k = 1; k <= 2 * L8 + 3; k++) begin
            checks++;
            if (obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL b2b_model cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
            if (k == L8 + 1) begin
                checks++;
                if (x8 !== 1'b1 || busy8 !== 1'b1 || idx8 !== 6'd0) begin
                    errors++;
                    $display("FAIL b2b_start cyc %0d got x=%b busy=%b exp x=1 busy=1",
                             k, x8, busy8);
                end
            end
            if (k > L8 + 1 && k <= L8 + 9) begin
                checks++;
                if (x8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_zero cyc %0d got %b exp 0", k, x8);
                end
            end
            if (done8) ndone++;
            tick(k <= L8, 8'h00, 1'b0);
        end
        checks++;
        if (ndone !== 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 2", ndone);
        end
    endtask

    task automatic test_ignore();
        int ndone;
        ndone = 0;
        tick(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 2 * L8; k++) begin
            checks++;
            if (obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL ignore_model cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
            if (done8) ndone++;
            tick(k == 3, (k == 3) ? 8'h3C : 8'h00, 1'b0);
        end
        checks++;
        if (ndone !== 1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done_count got %0d busy=%b exp 1 busy=0",
                     ndone, busy8);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        tick(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k < 4; k++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h5A, 1'b1);
        for (int k = 5; k <= 5 + L8; k++) begin
            checks++;
            if (obs8() !== {4'b0001, 6'd0} || obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
            if (done8) ndone++;
            tick(1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_done got %0d exp 0", ndone);
        end
    endtask

    task automatic test_width1();
        tick(1'b1, 8'h01, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (obs1() !== exp_of(q1)) begin
                errors++;
                $display("FAIL w1_model cyc %0d got %b exp %b",
                         k, obs1(), exp_of(q1));
            end
            if (k == 2) begin
                checks++;
                if (x1 !== 1'b1 || done1 !== (PAR_EN == 0)) begin
                    errors++;
                    $display("FAIL w1_data got x=%b done=%b exp x=1 done=%b",
                             x1, done1, PAR_EN == 0);
                end
            end
            tick(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_random();
        logic ld, rst;
        logic [7:0] d;
        for (int k = 0; k < 600; k++) begin
            ld = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            tick(ld, d, rst);
            checks++;
            if (obs8() !== exp_of(q8)) begin
                errors++;
                $display("FAIL rand_w8 cyc %0d got %b exp %b",
                         k, obs8(), exp_of(q8));
            end
            checks++;
            if (obs1() !== exp_of(q1)) begin
                errors++;
                $display("FAIL rand_w1 cyc %0d got %b exp %b",
                         k, obs1(), exp_of(q1));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        load = 1'b0;
        data_in = 8'h00;
        d1 = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_a5();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_width1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
